icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 122 ++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding
// miss with fill bypass and hit-under-miss; rdy low freezes all state.
module icache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        if_rdy,
  output logic [31:0] if_ins,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_ins
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [29:0]        miss_addr_q, miss_addr_d;
  logic               mc_req_q, mc_req_d;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];

  logic [INDEX_W-1:0] pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               bypass;
  logic               fill_en;
  logic               unused_pc_bits;

  assign pc_idx         = if_pc[INDEX_W+1:2];
  assign pc_tag         = if_pc[31:INDEX_W+2];
  assign fill_idx       = miss_addr_q[INDEX_W-1:0];
  assign fill_tag       = miss_addr_q[29:INDEX_W];
  assign unused_pc_bits = ^if_pc[1:0];

  assign hit     = rdy & if_valid & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign fill_en = (state_q == WAIT) & rdy & mc_done;
  // The word arriving from memory is forwarded if fetch is still asking for it.
  assign bypass  = fill_en & if_valid & (if_pc[31:2] == miss_addr_q);

  assign mc_req  = mc_req_q;
  assign mc_addr = {miss_addr_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mc_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mc_req_q    <= mc_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    mc_req_d    = mc_req_q;
    if_rdy      = 1'b0;
    if_ins      = 32'h0;

    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (if_valid && !hit) begin
            state_d     = WAIT;
            miss_addr_d = if_pc[31:2];
            mc_req_d    = 1'b1;
          end
        end
        WAIT: begin
          // Further misses while waiting are simply not answered.
          if (mc_done) begin
            state_d  = IDLE;
            mc_req_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bypass) begin
      if_rdy = 1'b1;
      if_ins = mc_ins;
    end else if (hit) begin
      if_rdy = 1'b1;
      if_ins = data_q[pc_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_ins;
    end
  end

endmodule
